// File: rtl/id_exe_stage_pkg.sv
// Shared encodings for the ID->EXE stage of the 5-stage MIPS core.
// Forwarding selects, operand-source selects, ALU operations and
// write-back source encodings are defined once here and imported
// by every file that needs them.
package id_exe_stage_pkg;

  // Operand forwarding select (exe_fwd_a_ctrl / exe_fwd_b_ctrl)
  typedef enum logic [1:0] {
    FWD_NO      = 2'd0,  // register-file read data from ID
    FWD_ALU_EXE = 2'd1,  // ALU result of the instruction now in EXE
    FWD_ALU_MEM = 2'd2,  // ALU result held in MEM
    FWD_MEM     = 2'd3   // load data returned in MEM
  } fwd_sel_e;

  // ALU operand A source
  localparam logic [1:0] EXE_A_RS   = 2'd0;
  localparam logic [1:0] EXE_A_PC   = 2'd1;
  localparam logic [1:0] EXE_A_ZERO = 2'd2;

  // ALU operand B source
  localparam logic [1:0] EXE_B_RT   = 2'd0;
  localparam logic [1:0] EXE_B_IMM  = 2'd1;
  localparam logic [1:0] EXE_B_FOUR = 2'd2;

  // ALU operation
  localparam logic [3:0] EXE_ALU_ADD = 4'd0;
  localparam logic [3:0] EXE_ALU_SUB = 4'd1;
  localparam logic [3:0] EXE_ALU_AND = 4'd2;
  localparam logic [3:0] EXE_ALU_OR  = 4'd3;
  localparam logic [3:0] EXE_ALU_XOR = 4'd4;
  localparam logic [3:0] EXE_ALU_NOR = 4'd5;
  localparam logic [3:0] EXE_ALU_SLT = 4'd6;
  localparam logic [3:0] EXE_ALU_SLL = 4'd7;
  localparam logic [3:0] EXE_ALU_SRL = 4'd8;
  localparam logic [3:0] EXE_ALU_SRA = 4'd9;
  localparam logic [3:0] EXE_ALU_LUI = 4'd10;

  // Write-back data source
  localparam logic WB_DATA_ALU = 1'b0;
  localparam logic WB_DATA_MEM = 1'b1;

endpackage

// File: rtl/id_exe_stage_fwd_mux.sv
// 4:1 operand forwarding mux placed in front of the ID->EXE register.
// Ports:
//   sel          in  2       forwarding select (fwd_sel_e encoding)
//   id_data      in  DATA_W  register-file read data
//   alu_out_exe  in  DATA_W  ALU result in EXE
//   alu_out_mem  in  DATA_W  ALU result in MEM
//   mem_dout_mem in  DATA_W  load data in MEM
//   dout         out DATA_W  selected operand
module id_exe_stage_fwd_mux
  import id_exe_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] id_data,
  input  logic [DATA_W-1:0] alu_out_exe,
  input  logic [DATA_W-1:0] alu_out_mem,
  input  logic [DATA_W-1:0] mem_dout_mem,
  output logic [DATA_W-1:0] dout
);

  always_comb begin
    dout = id_data;
    case (fwd_sel_e'(sel))
      FWD_NO:      dout = id_data;
      FWD_ALU_EXE: dout = alu_out_exe;
      FWD_ALU_MEM: dout = alu_out_mem;
      FWD_MEM:     dout = mem_dout_mem;
      default:     dout = id_data;
    endcase
  end

endmodule

// File: rtl/id_exe_stage.sv
// ID->EXE pipeline register of the 5-stage MIPS core.
// Executes the controller's exe_rst (flush to bubble) / exe_en (capture)
// commands, applies operand forwarding in front of the register, and
// returns registered EXE-stage feedback for hazard detection.
// Ports:
//   clk, rst (async, active-high)
//   exe_rst, exe_en           flush / enable commands (flush wins)
//   id_*, id_ctrl_*           ID-stage instruction fields and control
//   exe_fwd_a/b_ctrl          forwarding selects for rs / rt
//   alu_out_exe, alu_out_mem, mem_dout_mem   forwarding sources
//   exe_*                     registered copies of the ID fields
//   exe_valid                 EXE holds a real instruction
//   regw_addr_exe, wb_wen_exe, wb_data_src_exe, is_branch_exe  feedback
//   perf_issued, perf_bubbles counters
// Build option: define EXE_PERF_CNT_EN to implement the saturating
// performance counters; otherwise they read 0 and have no flops.
module id_exe_stage
  import id_exe_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exe_rst,
  input  logic                  exe_en,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_inst,
  input  logic [DATA_W-1:0]     id_data_rs,
  input  logic [DATA_W-1:0]     id_data_rt,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_regw_addr,
  input  logic [1:0]            id_ctrl_exe_a_src,
  input  logic [1:0]            id_ctrl_exe_b_src,
  input  logic [3:0]            id_ctrl_exe_alu_oper,
  input  logic                  id_ctrl_mem_ren,
  input  logic                  id_ctrl_mem_wen,
  input  logic                  id_ctrl_wb_data_src,
  input  logic                  id_ctrl_wb_wen,
  input  logic                  id_ctrl_is_branch,
  input  logic                  id_ctrl_fwd_m,
  input  logic [1:0]            exe_fwd_a_ctrl,
  input  logic [1:0]            exe_fwd_b_ctrl,
  input  logic [DATA_W-1:0]     alu_out_exe,
  input  logic [DATA_W-1:0]     alu_out_mem,
  input  logic [DATA_W-1:0]     mem_dout_mem,
  output logic [DATA_W-1:0]     exe_pc,
  output logic [DATA_W-1:0]     exe_inst,
  output logic [DATA_W-1:0]     exe_data_rs,
  output logic [DATA_W-1:0]     exe_data_rt,
  output logic [DATA_W-1:0]     exe_imm,
  output logic [REG_ADDR_W-1:0] exe_regw_addr,
  output logic [1:0]            exe_a_src,
  output logic [1:0]            exe_b_src,
  output logic [3:0]            exe_alu_oper,
  output logic                  exe_mem_ren,
  output logic                  exe_mem_wen,
  output logic                  exe_wb_data_src,
  output logic                  exe_wb_wen,
  output logic                  exe_is_branch,
  output logic                  exe_fwd_m,
  output logic                  exe_valid,
  output logic [REG_ADDR_W-1:0] regw_addr_exe,
  output logic                  wb_wen_exe,
  output logic                  wb_data_src_exe,
  output logic                  is_branch_exe,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_bubbles
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     inst;
    logic [DATA_W-1:0]     data_rs;
    logic [DATA_W-1:0]     data_rt;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] regw_addr;
    logic [1:0]            a_src;
    logic [1:0]            b_src;
    logic [3:0]            alu_oper;
    logic                  mem_ren;
    logic                  mem_wen;
    logic                  wb_data_src;
    logic                  wb_wen;
    logic                  is_branch;
    logic                  fwd_m;
  } stage_t;

  stage_t            stage_d, stage_q;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  id_exe_stage_fwd_mux #(.DATA_W(DATA_W)) u_fwd_mux_rs (
    .sel          (exe_fwd_a_ctrl),
    .id_data      (id_data_rs),
    .alu_out_exe  (alu_out_exe),
    .alu_out_mem  (alu_out_mem),
    .mem_dout_mem (mem_dout_mem),
    .dout         (fwd_rs)
  );

  id_exe_stage_fwd_mux #(.DATA_W(DATA_W)) u_fwd_mux_rt (
    .sel          (exe_fwd_b_ctrl),
    .id_data      (id_data_rt),
    .alu_out_exe  (alu_out_exe),
    .alu_out_mem  (alu_out_mem),
    .mem_dout_mem (mem_dout_mem),
    .dout         (fwd_rt)
  );

  // Flush beats enable; a bubble is the all-zero record (inst 0 = NOP).
  always_comb begin
    stage_d = stage_q;
    if (exe_rst) begin
      stage_d = '0;
    end else if (exe_en) begin
      stage_d.valid       = id_valid;
      stage_d.pc          = id_pc;
      stage_d.inst        = id_inst;
      stage_d.data_rs     = fwd_rs;
      stage_d.data_rt     = fwd_rt;
      stage_d.imm         = id_imm;
      stage_d.regw_addr   = id_regw_addr;
      stage_d.a_src       = id_ctrl_exe_a_src;
      stage_d.b_src       = id_ctrl_exe_b_src;
      stage_d.alu_oper    = id_ctrl_exe_alu_oper;
      stage_d.wb_data_src = id_ctrl_wb_data_src;
      stage_d.fwd_m       = id_ctrl_fwd_m;
      // Side-effecting controls are suppressed for a non-valid slot.
      stage_d.mem_ren     = id_ctrl_mem_ren   & id_valid;
      stage_d.mem_wen     = id_ctrl_mem_wen   & id_valid;
      stage_d.wb_wen      = id_ctrl_wb_wen    & id_valid;
      stage_d.is_branch   = id_ctrl_is_branch & id_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign exe_valid       = stage_q.valid;
  assign exe_pc          = stage_q.pc;
  assign exe_inst        = stage_q.inst;
  assign exe_data_rs     = stage_q.data_rs;
  assign exe_data_rt     = stage_q.data_rt;
  assign exe_imm         = stage_q.imm;
  assign exe_regw_addr   = stage_q.regw_addr;
  assign exe_a_src       = stage_q.a_src;
  assign exe_b_src       = stage_q.b_src;
  assign exe_alu_oper    = stage_q.alu_oper;
  assign exe_mem_ren     = stage_q.mem_ren;
  assign exe_mem_wen     = stage_q.mem_wen;
  assign exe_wb_data_src = stage_q.wb_data_src;
  assign exe_wb_wen      = stage_q.wb_wen;
  assign exe_is_branch   = stage_q.is_branch;
  assign exe_fwd_m       = stage_q.fwd_m;

  assign regw_addr_exe   = stage_q.regw_addr;
  assign wb_data_src_exe = stage_q.wb_data_src;
  assign wb_wen_exe      = stage_q.wb_wen    & stage_q.valid;
  assign is_branch_exe   = stage_q.is_branch & stage_q.valid;

`ifdef EXE_PERF_CNT_EN
  logic [31:0] perf_issued_d, perf_issued_q;
  logic [31:0] perf_bubbles_d, perf_bubbles_q;

  always_comb begin
    perf_issued_d  = perf_issued_q;
    perf_bubbles_d = perf_bubbles_q;
    if (exe_rst) begin
      if (perf_bubbles_q != '1) perf_bubbles_d = perf_bubbles_q + 32'd1;
    end else if (exe_en && id_valid) begin
      if (perf_issued_q != '1) perf_issued_d = perf_issued_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued_q  <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_issued_q  <= perf_issued_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_issued  = perf_issued_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  assign perf_issued  = '0;
  assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
module tb_id_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_rst, exe_en, id_valid;
  logic [31:0] id_pc, id_inst, id_data_rs, id_data_rt, id_imm;
  logic [4:0]  id_regw_addr;
  logic [1:0]  id_ctrl_exe_a_src, id_ctrl_exe_b_src;
  logic [3:0]  id_ctrl_exe_alu_oper;
  logic        id_ctrl_mem_ren, id_ctrl_mem_wen, id_ctrl_wb_data_src;
  logic        id_ctrl_wb_wen, id_ctrl_is_branch, id_ctrl_fwd_m;
  logic [1:0]  exe_fwd_a_ctrl, exe_fwd_b_ctrl;
  logic [31:0] alu_out_exe, alu_out_mem, mem_dout_mem;

  logic [31:0] exe_pc, exe_inst, exe_data_rs, exe_data_rt, exe_imm;
  logic [4:0]  exe_regw_addr, regw_addr_exe;
  logic [1:0]  exe_a_src, exe_b_src;
  logic [3:0]  exe_alu_oper;
  logic        exe_mem_ren, exe_mem_wen, exe_wb_data_src, exe_wb_wen;
  logic        exe_is_branch, exe_fwd_m, exe_valid;
  logic        wb_wen_exe, wb_data_src_exe, is_branch_exe;
  logic [31:0] perf_issued, perf_bubbles;

  int unsigned checks = 0;
  int unsigned errors = 0;

`ifdef EXE_PERF_CNT_EN
  localparam logic PERF_ON = 1'b1;
`else
  localparam logic PERF_ON = 1'b0;
`endif

  id_exe_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .exe_rst(exe_rst), .exe_en(exe_en), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .id_data_rs(id_data_rs), .id_data_rt(id_data_rt),
    .id_imm(id_imm), .id_regw_addr(id_regw_addr),
    .id_ctrl_exe_a_src(id_ctrl_exe_a_src), .id_ctrl_exe_b_src(id_ctrl_exe_b_src),
    .id_ctrl_exe_alu_oper(id_ctrl_exe_alu_oper), .id_ctrl_mem_ren(id_ctrl_mem_ren),
    .id_ctrl_mem_wen(id_ctrl_mem_wen), .id_ctrl_wb_data_src(id_ctrl_wb_data_src),
    .id_ctrl_wb_wen(id_ctrl_wb_wen), .id_ctrl_is_branch(id_ctrl_is_branch),
    .id_ctrl_fwd_m(id_ctrl_fwd_m), .exe_fwd_a_ctrl(exe_fwd_a_ctrl),
    .exe_fwd_b_ctrl(exe_fwd_b_ctrl), .alu_out_exe(alu_out_exe),
    .alu_out_mem(alu_out_mem), .mem_dout_mem(mem_dout_mem),
    .exe_pc(exe_pc), .exe_inst(exe_inst), .exe_data_rs(exe_data_rs),
    .exe_data_rt(exe_data_rt), .exe_imm(exe_imm), .exe_regw_addr(exe_regw_addr),
    .exe_a_src(exe_a_src), .exe_b_src(exe_b_src), .exe_alu_oper(exe_alu_oper),
    .exe_mem_ren(exe_mem_ren), .exe_mem_wen(exe_mem_wen),
    .exe_wb_data_src(exe_wb_data_src), .exe_wb_wen(exe_wb_wen),
    .exe_is_branch(exe_is_branch), .exe_fwd_m(exe_fwd_m), .exe_valid(exe_valid),
    .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe),
    .wb_data_src_exe(wb_data_src_exe), .is_branch_exe(is_branch_exe),
    .perf_issued(perf_issued), .perf_bubbles(perf_bubbles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] ra,
                        input logic wb_wen);
    id_valid       = v;
    id_pc          = pc;
    id_inst        = inst;
    id_data_rs     = rs;
    id_data_rt     = rt;
    id_regw_addr   = ra;
    id_ctrl_wb_wen = wb_wen;
  endtask

  initial begin
    rst = 1'b1; exe_rst = 1'b0; exe_en = 1'b0;
    set_id(1'b0, '0, '0, '0, '0, '0, 1'b0);
    id_imm = '0; id_ctrl_exe_a_src = '0; id_ctrl_exe_b_src = '0; id_ctrl_exe_alu_oper = '0;
    id_ctrl_mem_ren = 1'b0; id_ctrl_mem_wen = 1'b0; id_ctrl_wb_data_src = 1'b0;
    id_ctrl_is_branch = 1'b0; id_ctrl_fwd_m = 1'b0;
    exe_fwd_a_ctrl = 2'd0; exe_fwd_b_ctrl = 2'd0;
    alu_out_exe = 32'h55; alu_out_mem = 32'h77; mem_dout_mem = 32'hAA;

    // Reset state
    step();
    check("rst_valid", exe_valid, 0);
    check("rst_inst", exe_inst, 0);
    check("rst_pc", exe_pc, 0);
    check("rst_issued", perf_issued, 0);
    @(negedge clk); rst = 1'b0;

    // Issue 1: add $t2,$t0,$t1 -> r10, no forwarding
    exe_en = 1'b1;
    set_id(1'b1, 32'h100, 32'h0109_5020, 32'h11, 32'h22, 5'd10, 1'b1);
    id_imm = 32'h1234;
    step();
    check("add_valid", exe_valid, 1);
    check("add_regw_fb", regw_addr_exe, 10);
    check("add_wbwen_fb", wb_wen_exe, 1);
    check("add_inst", exe_inst, 32'h0109_5020);
    check("add_pc", exe_pc, 32'h100);
    check("add_rs_nofwd", exe_data_rs, 32'h11);
    check("add_rt_nofwd", exe_data_rt, 32'h22);
    check("add_imm", exe_imm, 32'h1234);

    // Issue 2: rs from EXE ALU, rt from MEM load data
    @(negedge clk);
    exe_fwd_a_ctrl = 2'd1; exe_fwd_b_ctrl = 2'd3;
    set_id(1'b1, 32'h104, 32'h0109_5022, 32'h11, 32'h11, 5'd11, 1'b1);
    step();
    check("fwd_rs_aluexe", exe_data_rs, 32'h55);
    check("fwd_rt_memdout", exe_data_rt, 32'hAA);

    // Issue 3: rs from MEM ALU, rt no forwarding
    @(negedge clk);
    exe_fwd_a_ctrl = 2'd2; exe_fwd_b_ctrl = 2'd0;
    set_id(1'b1, 32'h108, 32'h0109_5024, 32'h11, 32'h22, 5'd12, 1'b1);
    step();
    check("fwd_rs_alumem", exe_data_rs, 32'h77);
    check("fwd_rt_none", exe_data_rt, 32'h22);

    // Hold: three edges of changing ID contents with enable low
    @(negedge clk);
    exe_en = 1'b0; exe_fwd_a_ctrl = 2'd0;
    for (int i = 0; i < 3; i++) begin
      set_id(i[0], 32'h200 + i, 32'hDEAD_0000 + i, 32'h900 + i, 32'h800 + i, 5'd20 + 5'(i), 1'b0);
      step();
      check("hold_inst", exe_inst, 32'h0109_5024);
      check("hold_rs", exe_data_rs, 32'h77);
      check("hold_regw", regw_addr_exe, 12);
      check("hold_valid", exe_valid, 1);
      @(negedge clk);
    end

    // Flush and enable together: flush wins
    exe_rst = 1'b1; exe_en = 1'b1;
    set_id(1'b1, 32'h300, 32'h0109_5020, 32'h33, 32'h44, 5'd9, 1'b1);
    step();
    check("flush_valid", exe_valid, 0);
    check("flush_wbwen", wb_wen_exe, 0);
    check("flush_regw", regw_addr_exe, 0);
    check("flush_inst", exe_inst, 0);
    check("flush_rs", exe_data_rs, 0);
    check("flush_pc", exe_pc, 0);

    // Capture of a non-valid slot: side-effect controls forced low
    @(negedge clk);
    exe_rst = 1'b0;
    set_id(1'b0, 32'h304, 32'hAC00_0000, 32'h1, 32'h2, 5'd7, 1'b1);
    id_ctrl_mem_wen = 1'b1; id_ctrl_mem_ren = 1'b1; id_ctrl_is_branch = 1'b1;
    step();
    check("inv_valid", exe_valid, 0);
    check("inv_wbwen", exe_wb_wen, 0);
    check("inv_memwen", exe_mem_wen, 0);
    check("inv_memren", exe_mem_ren, 0);
    check("inv_branch_fb", is_branch_exe, 0);
    check("inv_regw", exe_regw_addr, 7);

    // Issue 4: load with fwd_m, wb from memory, ALU controls
    @(negedge clk);
    set_id(1'b1, 32'h308, 32'h8C0A_0004, 32'h5, 32'h6, 5'd10, 1'b1);
    id_ctrl_mem_wen = 1'b0; id_ctrl_is_branch = 1'b0;
    id_ctrl_fwd_m = 1'b1; id_ctrl_wb_data_src = 1'b1;
    id_ctrl_exe_a_src = 2'd1; id_ctrl_exe_b_src = 2'd2; id_ctrl_exe_alu_oper = 4'd6;
    step();
    check("ld_memren", exe_mem_ren, 1);
    check("ld_fwdm", exe_fwd_m, 1);
    check("ld_wbsrc_fb", wb_data_src_exe, 1);
    check("ld_ctrl", {exe_a_src, exe_b_src, exe_alu_oper}, 8'b01_10_0110);

    // Issue 5: branch
    @(negedge clk);
    set_id(1'b1, 32'h30C, 32'h1000_0003, 32'h5, 32'h6, 5'd0, 1'b0);
    id_ctrl_mem_ren = 1'b0; id_ctrl_fwd_m = 1'b0; id_ctrl_is_branch = 1'b1;
    step();
    check("br_branch_fb", is_branch_exe, 1);
    check("br_memren", exe_mem_ren, 0);

    // Second flush
    @(negedge clk);
    exe_rst = 1'b1;
    step();
    check("flush2_branch_fb", is_branch_exe, 0);
    check("perf_issued", perf_issued, PERF_ON ? 32'd5 : 32'd0);
    check("perf_bubbles", perf_bubbles, PERF_ON ? 32'd2 : 32'd0);

    // Asynchronous reset mid-run with a valid instruction in EXE
    @(negedge clk);
    exe_rst = 1'b0; id_ctrl_is_branch = 1'b0;
    set_id(1'b1, 32'h400, 32'h0109_5020, 32'h12, 32'h34, 5'd3, 1'b1);
    step();
    check("pre_arst_valid", exe_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", exe_valid, 0);
    check("arst_inst", exe_inst, 0);
    check("arst_pc", exe_pc, 0);
    check("arst_wbwen", wb_wen_exe, 0);
    check("arst_issued", perf_issued, 0);
    check("arst_bubbles", perf_bubbles, 0);

    // First capture on first edge after release
    @(negedge clk); rst = 1'b0;
    step();
    check("post_arst_regw", regw_addr_exe, 3);
    check("post_arst_rs", exe_data_rs, 32'h12);
    check("post_arst_issued", perf_issued, PERF_ON ? 32'd1 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
